// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the serial pattern transmitter.
// Holds the FSM state encoding, default pattern width and counter-width functions.
package serial_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int REP_W         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to hold a length of 0..width.
  function automatic int len_w(input int width);
    return $clog2(width) + 1;
  endfunction

  // Gap counter counts gap-1 down to 0; keep at least one bit when gap is 0.
  function automatic int gap_w(input int gap);
    return (gap < 2) ? 1 : $clog2(gap);
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load shift register presenting its MSB as the serial bit.
// Clear has priority over load, load over shift; the MSB flop drives x directly.
module pattern_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_value,
  output logic             msb
);

  logic [WIDTH-1:0] sr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_reg <= '0;
    end else if (clear) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= load_value;
    end else if (shift) begin
      sr_reg <= sr_reg << 1;
    end
  end

  assign msb = sr_reg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a loaded pattern MSB-first for load_rep+1 passes,
// optionally separated by idle gaps, then pulses done for one cycle.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [$clog2(WIDTH):0] load_len,
  input  logic [REP_W-1:0]       load_rep,
  input  logic                   abort,
  output logic                   x,
  output logic                   x_valid,
  output logic                   done
);

  localparam int LEN_W = len_w(WIDTH);
  localparam int GAP_W = gap_w(GAP_CYCLES);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   bit_reg, bit_next;
  logic [REP_W-1:0]   pass_reg, pass_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [WIDTH-1:0]   cap_reg, cap_next;
  logic               x_valid_reg, done_reg;

  logic [LEN_W-1:0]   eff_len;
  logic [WIDTH-1:0]   aligned;
  logic               sr_clear, sr_load, sr_shift;
  logic [WIDTH-1:0]   sr_load_value;

  // Left-align the active field so the shifter always emits from its top bit.
  assign eff_len = (load_len == '0 || load_len > FULL_LEN) ? FULL_LEN : load_len;
  assign aligned = load_data << (FULL_LEN - eff_len);

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    bit_next      = bit_reg;
    pass_next     = pass_reg;
    gap_next      = gap_reg;
    cap_next      = cap_reg;
    sr_clear      = 1'b0;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    sr_load_value = cap_reg;

    unique case (state_reg)
      IDLE: begin
        if (load_valid) begin
          state_next    = SHIFT;
          sr_load       = 1'b1;
          sr_load_value = aligned;
          cap_next      = aligned;
          len_next      = eff_len;
          bit_next      = eff_len - LEN_W'(1);
          pass_next     = load_rep;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
          sr_clear   = 1'b1;
        end else if (bit_reg != '0) begin
          sr_shift = 1'b1;
          bit_next = bit_reg - LEN_W'(1);
        end else if (pass_reg != '0) begin
          pass_next = pass_reg - REP_W'(1);
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            sr_clear   = 1'b1;
            gap_next   = GAP_W'(GAP_CYCLES - 1);
          end else begin
            sr_load  = 1'b1;
            bit_next = len_reg - LEN_W'(1);
          end
        end else begin
          state_next = DONE;
          sr_clear   = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (gap_reg == '0) begin
          state_next = SHIFT;
          sr_load    = 1'b1;
          bit_next   = len_reg - LEN_W'(1);
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        sr_clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      bit_reg     <= '0;
      pass_reg    <= '0;
      gap_reg     <= '0;
      cap_reg     <= '0;
      x_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      bit_reg     <= bit_next;
      pass_reg    <= pass_next;
      gap_reg     <= gap_next;
      cap_reg     <= cap_next;
      x_valid_reg <= (state_next == SHIFT);
      done_reg    <= (state_next == DONE);
    end
  end

  pattern_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (sr_clear),
    .load       (sr_load),
    .shift      (sr_shift),
    .load_value (sr_load_value),
    .msb        (x)
  );

  assign load_ready = (state_reg == IDLE);
  assign x_valid    = x_valid_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx (WIDTH=8, GAP_CYCLES=1).
// Expected per-cycle outputs {x_valid, x, done, load_ready} are queued, then drained against the DUT.
module tb_serial_pattern_tx;

  localparam int W   = 8;
  localparam int GAP = 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 load_valid = 1'b0;
  logic                 load_ready;
  logic [W-1:0]         load_data = '0;
  logic [$clog2(W):0]   load_len = '0;
  logic [3:0]           load_rep = '0;
  logic                 abort = 1'b0;
  logic                 x, x_valid, done;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_rep   (load_rep),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference sequence built straight from the pattern definition.
  task automatic push_model(input logic [W-1:0] d, input int len, input int rep);
    int eff;
    eff = (len == 0) ? W : len;
    for (int p = 0; p <= rep; p++) begin
      for (int i = eff - 1; i >= 0; i--) exp_q.push_back({1'b1, d[i], 1'b0, 1'b0});
      if (p < rep) for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
  endtask

  task automatic check_now(input string name, input int idx, input logic [3:0] expv);
    logic [3:0] obs;
    obs = {x_valid, x, done, load_ready};
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s item %0d: got {xv,x,done,rdy}=%b expected %b", name, idx, obs, expv);
    end
  endtask

  // evt_kind: 0 none, 1 abort, 2 stray load; the event is driven right after item evt_idx.
  task automatic run(input string name, input logic [W-1:0] d, input int len, input int rep,
                     input int evt_idx, input int evt_kind, input bit abort_with_load);
    int idx;
    int n;
    n = exp_q.size();
    @(negedge clk);
    load_data  = d;
    load_len   = len[$clog2(W):0];
    load_rep   = rep[3:0];
    load_valid = 1'b1;
    abort      = abort_with_load;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      load_valid = 1'b0;
      abort      = 1'b0;
      check_now(name, idx, exp_q.pop_front());
      if (idx == evt_idx && evt_kind == 1) abort = 1'b1;
      if (idx == evt_idx && evt_kind == 2) begin
        load_valid = 1'b1;
        load_data  = ~d;
        load_len   = 4'd2;
        load_rep   = 4'd0;
      end
      idx++;
    end
    $display("tx %s: data=%h len=%0d rep=%0d cycles_checked=%0d", name, d, len, rep, n);
  endtask

  task automatic test_reset();
    #3;
    check_now("reset", 0, 4'b0001);
    @(negedge clk);
    check_now("reset", 1, 4'b0001);
    reset_n = 1'b1;
    @(negedge clk);
    check_now("reset", 2, 4'b0001);
    $display("tx reset: outputs idle, load_ready high");
  endtask

  task automatic test_basic();
    push_model(8'b0000_0101, 3, 0);
    run("basic", 8'b0000_0101, 3, 0, -1, 0, 1'b0);
  endtask

  task automatic test_repeat();
    push_model(8'b0000_0101, 3, 2);
    run("repeat", 8'b0000_0101, 3, 2, -1, 0, 1'b0);
  endtask

  task automatic test_full_len();
    push_model(8'hA5, 0, 0);
    run("full_len", 8'hA5, 0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_max_rep();
    push_model(8'b0000_0010, 2, 15);
    run("max_rep", 8'b0000_0010, 2, 15, -1, 0, 1'b0);
  endtask

  task automatic test_len_one();
    push_model(8'b1111_1110, 1, 1);
    run("len_one", 8'b1111_1110, 1, 1, -1, 0, 1'b0);
  endtask

  task automatic test_ignored_load();
    push_model(8'b0000_0101, 3, 1);
    run("ignored_load", 8'b0000_0101, 3, 1, 1, 2, 1'b0);
  endtask

  task automatic test_abort();
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    run("abort", 8'b0000_0101, 3, 0, 1, 1, 1'b0);
  endtask

  task automatic test_abort_with_load();
    push_model(8'b0000_0110, 3, 0);
    run("abort_with_load", 8'b0000_0110, 3, 0, -1, 0, 1'b1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load_data  = 8'b0000_0101;
    load_len   = 4'd3;
    load_rep   = 4'd1;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check_now("async_reset", 0, 4'b1100);
    @(negedge clk);
    check_now("async_reset", 1, 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    check_now("async_reset", 2, 4'b0001);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_now("async_reset", 3, 4'b0001);
    $display("tx async_reset: outputs cleared without clock edge");
    push_model(8'b0000_0101, 3, 0);
    run("after_reset", 8'b0000_0101, 3, 0, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_full_len();
    test_max_rep();
    test_len_one();
    test_ignored_load();
    test_abort();
    test_abort_with_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
